// File: rtl/five_stage_hazard_detection_unit_pkg.sv
// Shared definitions for the five-stage hazard detection unit:
// FSM encodings and the bit layout of one shadow pipeline entry.
package five_stage_hazard_detection_unit_pkg;

  // Control FSM encodings.
  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_BUBBLE   = 2'd1,
    ST_MEM_WAIT = 2'd2
  } hazard_state_t;

  // Shadow entry layout, LSB first: is_load, regwrite, rd[addr_w-1:0], valid.
  localparam int ENTRY_IS_LOAD_OFS  = 0;
  localparam int ENTRY_REGWRITE_OFS = 1;
  localparam int ENTRY_RD_OFS       = 2;

  // Saturation value for the statistics counters.
  localparam logic [31:0] COUNTER_MAX = 32'hFFFF_FFFF;

  // Total width of one shadow entry for a given register index width.
  function automatic int entry_width(input int addr_w);
    return addr_w + 3;
  endfunction

  // Bit position of the valid flag for a given register index width.
  function automatic int entry_valid_ofs(input int addr_w);
    return addr_w + 2;
  endfunction

endpackage

// File: rtl/five_stage_hazard_detection_unit_stage_reg.sv
// One shadow pipeline entry {valid, rd, regwrite, is_load}.
// Clear has priority over load so a redirect always wins over an advance.
module five_stage_hazard_stage_reg
  import five_stage_hazard_detection_unit_pkg::*;
#(
  parameter int ADDR_W = 5
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          load_en,
  input  logic                          clear,
  input  logic [entry_width(ADDR_W)-1:0] d,
  output logic [entry_width(ADDR_W)-1:0] q
);

  // Entry register: async clear on reset, then clear > load > hold.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      q <= '0;
    end else if (clear) begin
      q <= '0;
    end else if (load_en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/five_stage_hazard_detection_unit.sv
// Hazard detection beside decode: keeps a shadow of the execute, memory and
// writeback instructions, flags per-stage source matches (execute > memory >
// writeback) and raises true_data_hazard/stall for load-use and for a load
// still waiting on data memory.
// Optional feature: define HAZARD_STATS_EN to build the stall and load-use
// counters; otherwise stall_cycles is tied to zero.
module five_stage_hazard_detection_unit
  import five_stage_hazard_detection_unit_pkg::*;
#(
  parameter int CORE            = 0,
  parameter int REG_ADDR_WIDTH  = 5,
  parameter int SCAN_CYCLES_MIN = 0,
  parameter int SCAN_CYCLES_MAX = 1000
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      decode_valid,
  input  logic [REG_ADDR_WIDTH-1:0] rs1,
  input  logic [REG_ADDR_WIDTH-1:0] rs2,
  input  logic                      rs1_used,
  input  logic                      rs2_used,
  input  logic [REG_ADDR_WIDTH-1:0] rd_decode,
  input  logic                      regwrite_decode,
  input  logic                      mem_read_decode,
  input  logic                      flush,
  input  logic                      dmem_ready,
  output logic                      true_data_hazard,
  output logic                      rs1_hazard_execute,
  output logic                      rs1_hazard_memory,
  output logic                      rs1_hazard_writeback,
  output logic                      rs2_hazard_execute,
  output logic                      rs2_hazard_memory,
  output logic                      rs2_hazard_writeback,
  output logic                      stall,
  output logic [31:0]               stall_cycles,
  input  logic                      scan
);

  localparam int EW        = entry_width(REG_ADDR_WIDTH);
  localparam int VALID_OFS = entry_valid_ofs(REG_ADDR_WIDTH);
  localparam int NSTAGE    = 3;  // index 0 = execute, 1 = memory, 2 = writeback

  hazard_state_t state_reg, state_next;

  logic [EW-1:0]             entry_q [NSTAGE];
  logic [EW-1:0]             entry_d [NSTAGE];
  logic [NSTAGE-1:0]         entry_load, entry_clear;
  logic [NSTAGE-1:0]         st_valid, st_regwrite, st_is_load;
  logic [REG_ADDR_WIDTH-1:0] st_rd [NSTAGE];
  logic [NSTAGE-1:0]         rs1_match, rs2_match, rs1_sel, rs2_sel;
  logic [EW-1:0]             decode_entry;
  logic                      src1_live, src2_live;
  logic                      load_use, load_pending, mem_wait, hazard;
  logic                      advance, accept, stall_int;
  logic [31:0]               cycle_reg;
  logic                      scan_window;
  logic                      unused_scan_tap;

  // A source can only hazard if decode is real, the source is read and it is not x0.
  assign src1_live = decode_valid & rs1_used & (rs1 != '0);
  assign src2_live = decode_valid & rs2_used & (rs2 != '0);

  // The shadow moves with the pipeline except while a load is waiting on memory.
  assign advance = (state_reg != ST_MEM_WAIT);

  // Shadow entries, their decoded fields and the raw per-stage source matches.
  genvar gi;
  generate
    for (gi = 0; gi < NSTAGE; gi++) begin : g_stage
      five_stage_hazard_stage_reg #(
        .ADDR_W(REG_ADDR_WIDTH)
      ) u_entry (
        .clock  (clock),
        .reset  (reset),
        .load_en(entry_load[gi]),
        .clear  (entry_clear[gi]),
        .d      (entry_d[gi]),
        .q      (entry_q[gi])
      );

      assign st_valid[gi]    = entry_q[gi][VALID_OFS];
      assign st_rd[gi]       = entry_q[gi][ENTRY_RD_OFS +: REG_ADDR_WIDTH];
      assign st_regwrite[gi] = entry_q[gi][ENTRY_REGWRITE_OFS];
      assign st_is_load[gi]  = entry_q[gi][ENTRY_IS_LOAD_OFS];

      assign rs1_match[gi] = st_valid[gi] & st_regwrite[gi] & (st_rd[gi] == rs1) & src1_live;
      assign rs2_match[gi] = st_valid[gi] & st_regwrite[gi] & (st_rd[gi] == rs2) & src2_live;

      assign entry_load[gi] = advance;

      if (gi == 0) begin : g_execute
        // Execute takes the decode instruction or a bubble; a flush clears it even when frozen.
        assign entry_d[gi]     = accept ? decode_entry : '0;
        assign entry_clear[gi] = flush;
      end else begin : g_older
        assign entry_d[gi]     = entry_q[gi-1];
        assign entry_clear[gi] = 1'b0;
      end
    end
  endgenerate

  // Pack the decode-stage fields into the shadow entry layout.
  always_comb begin
    decode_entry                                  = '0;
    decode_entry[VALID_OFS]                       = 1'b1;
    decode_entry[ENTRY_RD_OFS +: REG_ADDR_WIDTH]  = rd_decode;
    decode_entry[ENTRY_REGWRITE_OFS]              = regwrite_decode;
    decode_entry[ENTRY_IS_LOAD_OFS]               = mem_read_decode;
  end

  // The youngest matching producer wins, so at most one flag per source is set.
  assign rs1_sel = {rs1_match[2] & ~|rs1_match[1:0], rs1_match[1] & ~rs1_match[0], rs1_match[0]};
  assign rs2_sel = {rs2_match[2] & ~|rs2_match[1:0], rs2_match[1] & ~rs2_match[0], rs2_match[0]};

  // A load in execute cannot be bypassed at all; a load in memory only once its data is back.
  // The memory case uses the resolved flag: a newer execute writer of the same register shadows it.
  assign load_use     = (rs1_match[0] | rs2_match[0]) & st_is_load[0];
  assign load_pending = (rs1_sel[1] | rs2_sel[1]) & st_is_load[1] & ~dmem_ready;
  assign hazard       = load_use | load_pending;
  assign mem_wait     = st_valid[1] & st_is_load[1] & ~dmem_ready;
  assign accept       = decode_valid & ~hazard & ~flush;
  assign stall_int    = hazard | (state_reg == ST_MEM_WAIT);

  // FSM state register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_reg <= ST_RUN;
    end else begin
      state_reg <= state_next;
    end
  end

  // FSM next state: a flush cancels the load-use bubble; a waiting load freezes the shadow.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_RUN, ST_BUBBLE: begin
        if (load_use && !flush) begin
          state_next = ST_BUBBLE;
        end else if (mem_wait) begin
          state_next = ST_MEM_WAIT;
        end else begin
          state_next = ST_RUN;
        end
      end
      ST_MEM_WAIT: begin
        if (dmem_ready) begin
          state_next = ST_RUN;
        end
      end
      default: state_next = ST_RUN;
    endcase
  end

  // Free-running cycle counter used to window the scan tap; wraps at 2^32.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cycle_reg <= '0;
    end else begin
      cycle_reg <= cycle_reg + 32'd1;
    end
  end

  // Scan tap: no printing in hardware, the window is kept for a debug harness to probe.
  assign scan_window = scan & (cycle_reg >= 32'(SCAN_CYCLES_MIN)) & (cycle_reg <= 32'(SCAN_CYCLES_MAX));
  assign unused_scan_tap = ^{scan_window, 32'(CORE)};

`ifdef HAZARD_STATS_EN
  logic [31:0] stall_cnt_reg;
  logic [31:0] load_use_cnt_reg;
  logic        unused_stats_tap;

  // Saturating counts of stalled cycles and of load-use bubbles actually inserted.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      stall_cnt_reg    <= '0;
      load_use_cnt_reg <= '0;
    end else begin
      if (stall_int && stall_cnt_reg != COUNTER_MAX) begin
        stall_cnt_reg <= stall_cnt_reg + 32'd1;
      end
      if (load_use && !flush && advance && load_use_cnt_reg != COUNTER_MAX) begin
        load_use_cnt_reg <= load_use_cnt_reg + 32'd1;
      end
    end
  end

  assign stall_cycles     = reset ? stall_cnt_reg : 32'd0;
  assign unused_stats_tap = ^load_use_cnt_reg;
`else
  assign stall_cycles = 32'd0;
`endif

  // Outputs are forced low while reset is held.
  assign true_data_hazard     = reset & hazard;
  assign rs1_hazard_execute   = reset & rs1_sel[0];
  assign rs1_hazard_memory    = reset & rs1_sel[1];
  assign rs1_hazard_writeback = reset & rs1_sel[2];
  assign rs2_hazard_execute   = reset & rs2_sel[0];
  assign rs2_hazard_memory    = reset & rs2_sel[1];
  assign rs2_hazard_writeback = reset & rs2_sel[2];
  assign stall                = reset & stall_int;

endmodule
